// File: rtl/program_counter.sv
// program_counter: fetch-side PC register with a small control FSM.
//
// Parameters
//   N            - address width
//   RESET_VECTOR - first fetch address after reset
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   seq_pc       in   PC+4 from the external adder
//   seq_cout     in   carry-out of the PC+4 adder
//   br_taken     in   conditional branch resolved taken
//   br_target    in   branch target address
//   jmp          in   unconditional jump
//   jmp_target   in   jump target address
//   halt         in   stop fetching once the current fetch is accepted
//   resume       in   leave HALT
//   fetch_ack    in   instruction memory accepted the current pc
//   pc           out  current PC (registered)
//   fetch_req    out  fetch request (registered, high only in FETCH)
//   misalign     out  sticky: a selected next PC was not word aligned
//   wrap         out  sticky: a sequential update carried out of the adder
//   state        out  BOOT=00, FETCH=01, HALT=10, FAULT=11
module program_counter #(
  parameter int unsigned    N            = 32,
  parameter logic [N-1:0]   RESET_VECTOR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] seq_pc,
  input  logic         seq_cout,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  input  logic         jmp,
  input  logic [N-1:0] jmp_target,
  input  logic         halt,
  input  logic         resume,
  input  logic         fetch_ack,
  output logic [N-1:0] pc,
  output logic         fetch_req,
  output logic         misalign,
  output logic         wrap,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t       state_q, state_n;
  logic [N-1:0] pc_q, pc_n, sel_pc;
  logic         fetch_req_q, fetch_req_n;
  logic         misalign_q, misalign_n;
  logic         wrap_q, wrap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      fetch_req_q <= 1'b0;
      misalign_q  <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      fetch_req_q <= fetch_req_n;
      misalign_q  <= misalign_n;
      wrap_q      <= wrap_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    misalign_n = misalign_q;
    wrap_n     = wrap_q;

    // Next-PC priority: jump over branch over sequential.
    if (jmp)           sel_pc = jmp_target;
    else if (br_taken) sel_pc = br_target;
    else               sel_pc = seq_pc;

    case (state_q)
      BOOT: state_n = FETCH;
      FETCH: begin
        if (fetch_ack) begin
          if (sel_pc[1:0] != 2'b00) begin
            // Misaligned target: keep the old pc and lock up.
            state_n    = FAULT;
            misalign_n = 1'b1;
          end else begin
            pc_n = sel_pc;
            if (!jmp && !br_taken && seq_cout) wrap_n = 1'b1;
            if (halt) state_n = HALT;
          end
        end
      end
      HALT: begin
        if (resume && !halt) state_n = FETCH;
      end
      FAULT: begin
        state_n    = FAULT;
        misalign_n = 1'b1;
      end
      default: state_n = FAULT;
    endcase

    // fetch_req is registered, so derive it from the state being entered.
    fetch_req_n = (state_n == FETCH);
  end

  assign pc        = pc_q;
  assign fetch_req = fetch_req_q;
  assign misalign  = misalign_q;
  assign wrap      = wrap_q;
  assign state     = state_q;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed-vector bench for program_counter.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same
// point, i.e. after the edge has settled. The PC+4 adder is modelled here.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seq_pc;
  logic        seq_cout;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        halt;
  logic        resume;
  logic        fetch_ack;
  logic [31:0] pc;
  logic        fetch_req;
  logic        misalign;
  logic        wrap;
  logic [1:0]  state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  assign {seq_cout, seq_pc} = {1'b0, pc} + 33'd4;

  program_counter #(
    .N            (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seq_pc     (seq_pc),
    .seq_cout   (seq_cout),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .halt       (halt),
    .resume     (resume),
    .fetch_ack  (fetch_ack),
    .pc         (pc),
    .fetch_req  (fetch_req),
    .misalign   (misalign),
    .wrap       (wrap),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check: pc, fetch_req, misalign, wrap, state.
  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                         input logic e_mis, input logic e_wrap, input logic [1:0] e_st);
    chk({tag, ".pc"},        pc,                 e_pc);
    chk({tag, ".fetch_req"}, {31'd0, fetch_req}, {31'd0, e_req});
    chk({tag, ".misalign"},  {31'd0, misalign},  {31'd0, e_mis});
    chk({tag, ".wrap"},      {31'd0, wrap},      {31'd0, e_wrap});
    chk({tag, ".state"},     {30'd0, state},     {30'd0, e_st});
  endtask

  initial begin
    rst = 1'b1; br_taken = 1'b0; br_target = '0; jmp = 1'b0; jmp_target = '0;
    halt = 1'b0; resume = 1'b0; fetch_ack = 1'b1;
    #1;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    chk_all("reset_held", 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;

    // Boot then sequential fetch; ack during BOOT is ignored.
    tick(); chk_all("boot_to_fetch", 32'h0, 1'b1, 1'b0, 1'b0, 2'b01);
    tick(); chk("seq1.pc", pc, 32'h4);
    tick(); chk("seq2.pc", pc, 32'h8);
    tick(); chk("seq3.pc", pc, 32'hC);
    tick(); chk("seq4.pc", pc, 32'h10);

    // Stall at 0x10; a jump without ack must be ignored.
    fetch_ack = 1'b0; jmp = 1'b1; jmp_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("stall", 32'h10, 1'b1, 1'b0, 1'b0, 2'b01);
    end
    jmp = 1'b0; fetch_ack = 1'b1;
    tick(); chk("stall_release.pc", pc, 32'h14);

    // Jump to 0x20, then jump vs branch priority.
    jmp = 1'b1; jmp_target = 32'h20;
    tick(); chk("jmp.pc", pc, 32'h20);
    jmp_target = 32'h100; br_taken = 1'b1; br_target = 32'h200;
    tick(); chk_all("prio", 32'h100, 1'b1, 1'b0, 1'b0, 2'b01);
    jmp = 1'b0; br_target = 32'h40;
    tick(); chk("branch.pc", pc, 32'h40);
    br_taken = 1'b0;

    // Halt with ack at 0x40 loads 0x44 then stops.
    halt = 1'b1;
    tick(); chk_all("halt", 32'h44, 1'b0, 1'b0, 1'b0, 2'b10);
    halt = 1'b0;
    tick(); chk_all("halt_ack_ignored", 32'h44, 1'b0, 1'b0, 1'b0, 2'b10);
    resume = 1'b1; halt = 1'b1;
    tick(); chk_all("resume_blocked", 32'h44, 1'b0, 1'b0, 1'b0, 2'b10);
    halt = 1'b0;
    tick(); chk_all("resume", 32'h44, 1'b1, 1'b0, 1'b0, 2'b01);
    resume = 1'b0;

    // Wrap: jump to top of memory, sequential step carries out.
    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    tick(); chk_all("pre_wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 2'b01);
    jmp = 1'b0;
    tick(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b1, 2'b01);
    tick(); chk_all("wrap_sticky", 32'h4, 1'b1, 1'b0, 1'b1, 2'b01);

    // Misaligned branch target faults; pc holds.
    br_taken = 1'b1; br_target = 32'h0000_0102;
    tick(); chk_all("fault", 32'h4, 1'b0, 1'b1, 1'b1, 2'b11);
    br_taken = 1'b0; jmp = 1'b1; jmp_target = 32'h80; resume = 1'b1;
    tick(); tick();
    chk_all("fault_terminal", 32'h4, 1'b0, 1'b1, 1'b1, 2'b11);
    jmp = 1'b0; resume = 1'b0;

    // Reset clears faults; then abort mid-fetch with a pending jump.
    rst = 1'b1;
    #1; chk_all("reset_from_fault", 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick(); rst = 1'b0;
    tick(); chk_all("reboot", 32'h0, 1'b1, 1'b0, 1'b0, 2'b01);
    jmp = 1'b1; jmp_target = 32'h80; fetch_ack = 1'b1;
    #2 rst = 1'b1;
    #1 chk_all("abort_async", 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick(); chk_all("abort_held", 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b0; jmp = 1'b0;
    tick(); chk_all("abort_reboot", 32'h0, 1'b1, 1'b0, 1'b0, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
